sr_excitation_driver: RTL
=========================

# sr_excitation_driver

Write controller that drives a WIDTH-bit bank of clocked, posedge, set/reset storage elements through their S/R inputs. It accepts a target word over a valid/ready handshake and computes per-bit excitation from the bank's fed-back Q. It pulses S/R, waits for the bank to settle and checks that Q matches the target. On mismatch it retries a bounded number of times, then ends with a one-cycle done or err pulse. It is the inverse of the SR storage element: it maps next-state onto excitation, and never drives S=R=1.

## Interface
- WIDTH, 8: bits in the driven bank; must be ≥ 1.
- PULSE_CYCLES, 1: cycles S/R stay asserted per drive attempt; must be ≥ 1.
- SETTLE_CYCLES, 1: cycles with S/R held 00 before the check; may be 0.
- MAX_RETRY, 2: extra drive attempts after the first failed check; may be 0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a target word is offered.
- req_ready  out  1  high only in IDLE; a transfer occurs on a rising edge where req_valid && req_ready.
- req_data  in  WIDTH  target Q value; sampled only at acceptance.
- q_fb  in  WIDTH  Q outputs of the driven bank.
- s_out  out  WIDTH  per-bit set excitation, registered.
- r_out  out  WIDTH  per-bit reset excitation, registered.
- done  out  1  one-cycle pulse: q_fb matched the target.
- err  out  1  one-cycle pulse: retries exhausted without a match.
- fail_mask  out  WIDTH  target ^ q_fb at the final failed check; holds until the next err or reset.

## Operation
- States are IDLE, DRIVE, SETTLE and CHECK.
- Excitation for bit i, with target t and current q:
  - t=1, q=0 → S=1, R=0.
  - t=0, q=1 → S=0, R=1.
  - Otherwise S=0, R=0.
  - (s_out & r_out) == 0 at all times, and s_out/r_out are 0 outside DRIVE.
- IDLE:
  - On acceptance, register the target and compute the excitation from q_fb sampled at the same edge.
  - If any bit differs, go to DRIVE and clear the retry counter.
  - If no bit differs, stay in IDLE and pulse done in the next cycle. Outputs stay 00.
- DRIVE: hold the registered excitation for PULSE_CYCLES cycles, then go to SETTLE. If SETTLE_CYCLES=0, go straight to CHECK.
- SETTLE: s_out = r_out = 0 for SETTLE_CYCLES cycles, then go to CHECK.
- CHECK is one cycle, comparing q_fb with the target:
  - Match → IDLE, with done high for one cycle.
  - Mismatch with retry count < MAX_RETRY → increment the count, recompute the excitation from the current q_fb, go to DRIVE.
  - Mismatch with retries exhausted → IDLE, with err high for one cycle and fail_mask loaded.
- done and err are never high together, and never high outside the cycle that follows the end of the operation.
- req_valid and req_data are ignored while not in IDLE. No queueing.
- Reset (asynchronous, any state, mid-pulse included):
  - State goes to IDLE and the retry counter to 0.
  - s_out, r_out, done, err and fail_mask go to 0.
  - req_ready is 1 while in IDLE, but no acceptance occurs while rst_n=0.

## Timing
- Cycle 0 is the acceptance edge; cycle n is the clock period after the n-th subsequent rising edge. P = PULSE_CYCLES, S = SETTLE_CYCLES.
- Already-matching target: done=1 in cycle 1 and req_ready=1 in cycle 1. Minimum accept-to-accept spacing is 1 cycle.
- First drive attempt:
  - s_out/r_out valid in cycles 1..P.
  - 00 in cycles P+1..P+S.
  - CHECK in cycle P+S+1.
- Success on the first attempt: done=1 and req_ready=1 in cycle P+S+2.
- Each retry adds P+S+1 cycles: the new excitation appears in the cycle after CHECK.
- Worst case: err in cycle (MAX_RETRY+1)·(P+S+1)+1.
- A posedge storage bank driven in cycle k shows the new Q in cycle k+1, so the CHECK placement is valid even with S=0.

## Test plan
Bench setup: WIDTH=8, P=1, S=1, MAX_RETRY=2. q_fb is driven by 8 behavioural posedge SR flip-flops (00 hold, 01 clear, 10 set), reset to 0x00.
- Reset, then target 0xA5: s_out=0xA5 and r_out=0x00 in cycle 1; done in cycle 4; q_fb=0xA5.
- With the bank at 0xA5, target 0x3C: s_out=0x18 and r_out=0x81 in cycle 1; done in cycle 4; q_fb=0x3C.
- Target equal to the current Q (0x3C): no S/R activity; done in cycle 1; back-to-back acceptance in cycle 1 succeeds.
- Bit 0 forced stuck at 0 in q_fb, target 0x01:
  - Three drive attempts, each with s_out=0x01.
  - err in cycle 10 and fail_mask=0x01.
  - done never asserts.
- Bit 2 stuck only until the first CHECK, target 0x04: one retry; done in cycle 7; err stays 0.
- Random excitation: every cycle satisfies (s_out & r_out)=0 and s_out/r_out are 0 outside DRIVE.
- rst_n pulsed low in cycle 1 of a drive:
  - s_out, r_out, done and err are 0 immediately.
  - req_ready=1 after release.
  - The next request completes normally.

Source files
------------

// File: rtl/sr_excitation_driver.sv
// sr_excitation_driver
// Write controller for a bank of posedge set/reset storage elements.
// A target word is accepted over a valid/ready handshake. Per-bit S/R
// excitation is derived from the bank's fed-back Q. The controller pulses
// S/R, lets the bank settle, and verifies Q against the target, with a
// bounded number of retries. It finishes with a one-cycle done or err pulse.
//
// Handshake: req_ready is high only while the FSM is idle. A transfer
// happens on a rising edge where req_valid && req_ready are both high.
// req_data is sampled only at that edge. Nothing is queued while busy.
//
// Excitation rule for a bit with target t and current q:
//   t=1,q=0 -> S=1 ; t=0,q=1 -> R=1 ; otherwise S=R=0.
// S and R therefore can never both be 1. They are non-zero only in DRIVE.

module sr_excitation_driver #(
    parameter int WIDTH         = 8,
    parameter int PULSE_CYCLES  = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] fail_mask,
    output logic [1:0]       dbg_state
);

    // Phase counter covers the longer of the pulse and settle windows.
    localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [RW-1:0]    retry_q,  retry_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] s_q,      s_d;
    logic [WIDTH-1:0] r_q,      r_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
    logic [WIDTH-1:0] fail_q,   fail_d;

    // Next-state and next-output logic for the write FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        target_d = target_q;
        s_d      = s_q;
        r_d      = r_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fail_d   = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    target_d = req_data;
                    if (req_data != q_fb) begin
                        // Excitation is computed from q_fb at the acceptance edge.
                        s_d     = req_data & ~q_fb;
                        r_d     = ~req_data & q_fb;
                        cnt_d   = '0;
                        retry_d = '0;
                        state_d = ST_DRIVE;
                    end else begin
                        // The bank already holds the target, so nothing is driven.
                        done_d = 1'b1;
                    end
                end
            end

            ST_DRIVE: begin
                if (cnt_q == PULSE_LAST) begin
                    s_d   = '0;
                    r_d   = '0;
                    cnt_d = '0;
                    // A posedge bank shows new Q one cycle after the drive,
                    // so skipping SETTLE still checks a valid Q.
                    state_d = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_CHECK: begin
                if (q_fb == target_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    // A retry uses the bank's present Q, so bits that did take
                    // are not driven again.
                    retry_d = retry_q + RW'(1);
                    s_d     = target_q & ~q_fb;
                    r_d     = ~target_q & q_fb;
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    fail_d  = target_q ^ q_fb;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                s_d     = '0;
                r_d     = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset drops S/R at once, even mid-pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            target_q <= '0;
            s_q      <= '0;
            r_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            target_q <= target_d;
            s_q      <= s_d;
            r_q      <= r_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign fail_mask = fail_q;
    assign dbg_state = state_q;

endmodule
